// File: rtl/address_register_bank.sv
// Bank of NUM_REGS address registers with transfer/address bus access and an auto-stepping burst sequencer.
// Optional build macro ADDR_REG_SATURATE_EN clamps steps at the range ends and raises a sticky o_sat.
module address_register_bank #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int LEN_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_load_transfer,
  input  logic              i_assert_transfer,
  input  logic              i_assert_address,
  input  logic              i_inc,
  input  logic              i_dec,
  input  logic              i_burst_start,
  input  logic [LEN_W-1:0]  i_burst_len,
  input  logic              i_burst_dir,
  input  logic              i_burst_ready,
  inout  wire  [WIDTH-1:0]  transfer_bus,
  output logic [WIDTH-1:0]  address_bus,
  output logic [WIDTH-1:0]  o_data,
  output logic              o_burst_busy,
  output logic              o_burst_valid,
  output logic              o_burst_done,
  output logic              o_sat
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WIDTH-1:0]  regs_d [NUM_REGS];
  logic [SEL_W-1:0]  bsel_q, bsel_d;
  logic              dir_q, dir_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              busy;
  logic [WIDTH:0]    man_res, burst_res;
  logic              addr_en;
  logic [WIDTH-1:0]  addr_val;

  // Result MSB flags a step that was blocked by clamping; the low bits are the new value.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] v, input logic up);
    logic [WIDTH-1:0] nxt;
    nxt = up ? v + ONE : v - ONE;
`ifdef ADDR_REG_SATURATE_EN
    if (up ? (v == '1) : (v == '0)) return {1'b1, v};
`endif
    return {1'b0, nxt};
  endfunction

  assign busy          = (state_q != IDLE);
  assign o_burst_busy  = busy;
  assign o_burst_valid = (state_q == RUN);
  assign o_burst_done  = (state_q == DONE);
  assign o_sat         = sat_q;
  assign o_data        = regs_q[i_sel];

  assign transfer_bus = i_assert_transfer ? regs_q[i_sel] : {WIDTH{1'bz}};

  // The burst owns the address bus for its whole RUN phase.
  assign addr_en     = (state_q == RUN) || (!busy && i_assert_address);
  assign addr_val    = (state_q == RUN) ? regs_q[bsel_q] : regs_q[i_sel];
  assign address_bus = addr_en ? addr_val : {WIDTH{1'bz}};

  always_comb begin
    regs_d    = regs_q;
    state_d   = state_q;
    bsel_d    = bsel_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    man_res   = '0;
    burst_res = '0;

    if (!(busy && (i_sel == bsel_q))) begin
      if (i_load_transfer) begin
        regs_d[i_sel] = transfer_bus;
      end else if (i_inc != i_dec) begin
        man_res       = step(regs_q[i_sel], i_inc);
        regs_d[i_sel] = man_res[WIDTH-1:0];
        sat_d         = sat_d | man_res[WIDTH];
      end
    end

    case (state_q)
      IDLE: begin
        if (i_burst_start) begin
          bsel_d  = i_sel;
          dir_d   = i_burst_dir;
          cnt_d   = i_burst_len;
          state_d = (i_burst_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (i_burst_ready) begin
          burst_res      = step(regs_q[bsel_q], !dir_q);
          regs_d[bsel_q] = burst_res[WIDTH-1:0];
          sat_d          = sat_d | burst_res[WIDTH];
          cnt_d          = cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      state_q <= IDLE;
      bsel_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      state_q <= state_d;
      bsel_q  <= bsel_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: doc/address_register_bank.md
Name: address_register_bank

Overview:
Parametrised successor to the single 16-bit address register. It holds NUM_REGS clocked address registers that can be loaded from, and driven onto, the shared transfer bus. Any one register can drive the RAM/ROM address bus. A burst sequencer auto-steps one register per accepted beat, so block copies and stack walks need no per-beat control from the sequencer.

Parameters:
WIDTH, 16, width of each register, transfer_bus and address_bus
NUM_REGS, 4, number of address registers (power of two, >=2)
SEL_W, $clog2(NUM_REGS), register-select width
LEN_W, 8, burst length counter width

Ports:
i_clk  input  1  clock, all state changes on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_sel  input  SEL_W  register targeted by manual commands and assert strobes
i_load_transfer  input  1  latch transfer_bus into reg[i_sel]
i_assert_transfer  input  1  drive reg[i_sel] onto transfer_bus (combinational)
i_assert_address  input  1  drive reg[i_sel] onto address_bus (combinational)
i_inc  input  1  reg[i_sel] += 1
i_dec  input  1  reg[i_sel] -= 1
i_burst_start  input  1  start burst on reg[i_sel]
i_burst_len  input  LEN_W  beats in burst
i_burst_dir  input  1  0 = ascending, 1 = descending
i_burst_ready  input  1  consumer accepts current beat
transfer_bus  inout  WIDTH  shared transfer bus, Z when not asserted
address_bus  output  WIDTH  RAM/ROM address, Z when not driven
o_data  output  WIDTH  reg[i_sel], always visible
o_burst_busy  output  1  burst FSM not IDLE
o_burst_valid  output  1  address_bus holds a valid burst beat
o_burst_done  output  1  one-cycle pulse at burst end
o_sat  output  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all regs = 0, FSM = IDLE, o_burst_busy/valid/done = 0, o_sat = 0, both buses Z.
- Manual commands are sampled on the rising edge. Priority: load > inc > dec. inc and dec together with no load = no change.
- Arithmetic is modulo 2^WIDTH by default. 0xFFFF + 1 = 0x0000 and 0x0000 - 1 = 0xFFFF (WIDTH = 16).
- The transfer_bus load uses the value present at the edge. Asserting and loading the same register in the same cycle leaves it unchanged.
- FSM states: IDLE, RUN, DONE.
- IDLE + i_burst_start:
  - Latch bsel = i_sel, dir = i_burst_dir, cnt = i_burst_len.
  - If len != 0, go to RUN.
  - If len == 0, go to DONE with no beats.
- RUN:
  - o_burst_valid = 1, and address_bus = reg[bsel].
  - On a cycle with valid && ready: reg[bsel] steps by ±1 per dir, and cnt -= 1.
  - If cnt was 1 on that cycle, go to DONE.
  - With ready low, address and state hold indefinitely.
- DONE: o_burst_done = 1 for exactly one cycle, then IDLE. reg[bsel] holds the address after the last beat.
- o_burst_busy = 1 in RUN and DONE.
- While busy:
  - i_burst_start is ignored.
  - Manual load/inc/dec with i_sel == bsel are ignored; other registers operate normally.
  - i_assert_address is ignored because the burst owns address_bus.
  - i_assert_transfer still works for any register.
- Async reset mid-burst aborts immediately with no done pulse.

Optional Feature:
ADDR_REG_SATURATE_EN
- Defined:
  - inc/step-up at all-ones holds the value; dec/step-down at 0 holds.
  - Any blocked step sets o_sat, which clears only on reset.
  - A burst continues counting beats while clamped.
- Undefined: modulo wrap, and o_sat is tied to 0.

Test Plan:
- Reset, then load 0x1234 into reg2 via transfer_bus; assert_transfer on sel=2 -> transfer_bus = 0x1234, o_data = 0x1234, other regs 0.
- reg1 = 0xFFFF, i_inc -> 0x0000 (default build); with ADDR_REG_SATURATE_EN -> stays 0xFFFF, o_sat = 1.
- reg0 = 0x0100, burst len = 4, dir = 0, ready toggling 1,0,1,1,1 -> address_bus beats 0x0100, 0x0101, 0x0102, 0x0103; done pulse one cycle after 4th accept; reg0 = 0x0104.
- Burst len = 0 -> no valid, done pulse the cycle after start, busy high for that one cycle.
- During burst on reg3 (descending from 0x0010): inc to reg3 ignored, load to reg1 = 0xABCD succeeds, second i_burst_start ignored.
- Assert i_rst_n low mid-burst -> busy/valid drop immediately, all regs 0, buses Z, no done pulse.
